rom_loader: RTL
===============

Name: rom_loader

Overview:
- Initiator for the SoC ROM-load port (rom_we / rom_select / rom_addr / rom_wd / rom_rd), the port that program and exception memory expose for loading.
- Accepts a valid/ready word stream and writes it sequentially into program ROM (sel=0) or exception ROM (sel=1) from address 0.
- Holds the CPU in reset via cpu_hold while loading.
- Optionally reads the image back and checks it against a running checksum.

Parameters:
- ADDR_W, 6, ROM word-address width.
- DATA_W, 32, ROM word width.
- DEPTH, 64, ROM depth in words; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset; rst=0 resets
- start  in  1  one-cycle load request; ignored unless IDLE
- sel  in  1  target ROM: 0=program, 1=exception; sampled on start
- count  in  ADDR_W+1  number of words to load, 0..DEPTH; sampled on start
- s_valid  in  1  stream word valid
- s_data  in  DATA_W  stream word
- s_ready  out  1  loader accepts s_data this cycle
- rom_we  out  1  ROM write enable
- rom_select  out  1  ROM select, drives the SoC rom_select
- rom_addr  out  ADDR_W  ROM write/readback address
- rom_wd  out  DATA_W  ROM write data
- rom_rd  in  DATA_W  ROM readback data; combinational read of rom_addr
- cpu_hold  out  1  OR into the SoC reset; 1 while loading
- busy  out  1  1 in any state other than IDLE
- done  out  1  one-cycle pulse on load completion
- err  out  1  verify mismatch; sticky until next accepted start
- words_loaded  out  ADDR_W+1  beats written during the current or last load

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE.
  - All outputs 0: s_ready, rom_we, rom_select, rom_addr, rom_wd, cpu_hold, busy, done, err, words_loaded.
  - Checksum registers cleared.
- rom_we is gated with rst, so it is 0 in any cycle where rst=0, including mid-load. No partial-beat write occurs.
- States: IDLE, WRITE, VERIFY, CHECK, DONE.
- IDLE, on start=1:
  - Latch sel into rom_select.
  - Latch min(count, DEPTH) into len.
  - Clear addr, words_loaded, wsum, rsum and err.
  - Set cpu_hold=1.
  - Next state: DONE if len==0, else WRITE.
- WRITE:
  - s_ready=1; rom_addr=addr; rom_wd=s_data; rom_we=s_valid (combinational).
  - A beat is a cycle with s_valid & s_ready. On each beat: addr+1, words_loaded+1, wsum = wsum + s_data mod 2^DATA_W.
  - On the beat where words_loaded==len-1:
    - addr wraps to 0.
    - Next state is VERIFY with the feature enabled, else DONE.
  - With s_valid=0 the loader waits indefinitely; no timeout.
- VERIFY:
  - s_ready=0, rom_we=0, rom_addr=addr.
  - Each cycle: rsum = rsum + rom_rd, addr+1.
  - After len reads, next state CHECK.
  - Latency: exactly len cycles.
- CHECK: err = (rsum != wsum). Next state DONE.
- DONE:
  - done=1 for exactly one cycle.
  - cpu_hold=0 from the following cycle.
  - Next state IDLE.
  - rom_select holds its value until the next start.
- rom_select, len and cpu_hold are stable for the entire busy interval.
- start while busy is ignored, with no effect on state or counters.
- count > DEPTH is clamped to DEPTH. A full load (count=DEPTH) writes addresses 0..DEPTH-1 exactly once.
- Load latency, no stalls:
  - Feature enabled: 1 (accept) + len + len + 1 (CHECK) + 1 (DONE) cycles.
  - Feature disabled: 1 + len + 1 cycles.

Optional Feature:
- Macro: ROM_LOADER_VERIFY_EN.
- Defined: VERIFY and CHECK states, the rsum/wsum registers and err are implemented as above.
- Undefined: WRITE goes directly to DONE after the last beat. VERIFY/CHECK and the checksum logic are not synthesized. err is tied 0 and rom_rd is unused.

Test Plan:
- Reset: rst=0 for 2 cycles mid-idle -> all outputs 0, state IDLE.
- Program load: start, sel=0, count=4, data 0x11,0x22,0x33,0x44 with continuous valid -> rom_we pulses at addresses 0..3, rom_select=0, words_loaded=4, done one pulse, cpu_hold high from start through DONE, err=0.
- Exception load with stalls: sel=1, count=64, s_valid toggled 1/0 -> 64 writes at addresses 0..63 in order, no write when s_valid=0, rom_select=1 throughout, addr wraps to 0.
- Verify fail (VERIFY_EN): ROM model corrupts address 2 on write -> err=1 at done and stays 1 until next start; a clean reload clears it.
- Edge cases:
  - count=0 -> done 2 cycles after start, no rom_we.
  - count=100 -> clamped to 64.
  - start pulsed during WRITE -> ignored.
- Reset mid-load: rst=0 after 3 of 8 beats -> rom_we=0 that cycle, IDLE, cpu_hold=0, no done pulse.

Source files
------------

// File: rtl/rom_loader.sv
// rom_loader: initiator for the SoC ROM-load port.
// Accepts a valid/ready word stream and writes it sequentially, from address 0,
// into program ROM (sel=0) or exception ROM (sel=1). The CPU is held in reset
// through cpu_hold while a load is in progress.
//
// Optional feature macro: ROM_LOADER_VERIFY_EN
//   defined   : after the last write the image is read back through rom_rd,
//               summed, and compared against the running write checksum; err
//               reports a mismatch and stays set until the next accepted start.
//   undefined : no readback; err is tied 0 and rom_rd is unused.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   start/sel/count load request (IDLE only), target ROM, word count (clamped to DEPTH)
//   s_valid/s_data  input word stream, s_ready accepts a word
//   rom_we/rom_select/rom_addr/rom_wd/rom_rd  SoC ROM-load port
//   cpu_hold        OR into the SoC reset while loading
//   busy/done/err   status: not idle, one-cycle completion pulse, verify mismatch
//   words_loaded    beats written during the current or last load
//
// DEPTH must equal 2**ADDR_W.
module rom_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sel,
  input  logic [ADDR_W:0]   count,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              rom_we,
  output logic              rom_select,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_wd,
  input  logic [DATA_W-1:0] rom_rd,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {IDLE, WRITE, VERIFY, CHECK, DONE} state_t;

  localparam logic [ADDR_W:0]   MAX_LEN = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_W   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  state_t              state, state_nx;
  logic [ADDR_W:0]     len;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W:0]     len_in;
  logic [ADDR_W:0]     last_idx;
  logic                beat;
  logic                last_beat;

  assign len_in    = (count > MAX_LEN) ? MAX_LEN : count;
  assign last_idx  = len - ONE_W;
  assign beat      = (state == WRITE) && s_valid;
  assign last_beat = beat && (words_loaded == last_idx);

`ifdef ROM_LOADER_VERIFY_EN
  logic [DATA_W-1:0] wsum, rsum;
  logic              err_q;
  logic              last_read;
  assign last_read = (addr == last_idx[ADDR_W-1:0]);
  assign err       = err_q;
`else
  logic rd_unused;
  assign rd_unused = ^rom_rd;
  assign err       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = (len_in == '0) ? DONE : WRITE;
`ifdef ROM_LOADER_VERIFY_EN
      WRITE:  if (last_beat) state_nx = VERIFY;
      VERIFY: if (last_read) state_nx = CHECK;
      CHECK:  state_nx = DONE;
`else
      WRITE:  if (last_beat) state_nx = DONE;
`endif
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic; rom_we is gated with rst so a reset cycle never writes.
  always_comb begin
    s_ready  = 1'b0;
    rom_we   = 1'b0;
    rom_addr = '0;
    rom_wd   = '0;
    busy     = (state != IDLE);
    done     = (state == DONE);
    case (state)
      WRITE: begin
        s_ready  = 1'b1;
        rom_we   = s_valid & rst;
        rom_addr = addr;
        rom_wd   = s_data;
      end
`ifdef ROM_LOADER_VERIFY_EN
      VERIFY: rom_addr = addr;
`endif
      default: ;
    endcase
  end

  // Datapath: load parameters, address/beat counters, checksums
  always_ff @(posedge clk) begin
    if (!rst) begin
      rom_select   <= 1'b0;
      len          <= '0;
      addr         <= '0;
      words_loaded <= '0;
      cpu_hold     <= 1'b0;
`ifdef ROM_LOADER_VERIFY_EN
      wsum         <= '0;
      rsum         <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          rom_select   <= sel;
          len          <= len_in;
          addr         <= '0;
          words_loaded <= '0;
          cpu_hold     <= 1'b1;
`ifdef ROM_LOADER_VERIFY_EN
          wsum         <= '0;
          rsum         <= '0;
          err_q        <= 1'b0;
`endif
        end
        WRITE: if (beat) begin
          // Explicit wrap so readback starts at 0 even for partial loads.
          addr         <= last_beat ? '0 : addr + ONE_A;
          words_loaded <= words_loaded + ONE_W;
`ifdef ROM_LOADER_VERIFY_EN
          wsum         <= wsum + s_data;
`endif
        end
`ifdef ROM_LOADER_VERIFY_EN
        VERIFY: begin
          rsum <= rsum + rom_rd;
          addr <= last_read ? '0 : addr + ONE_A;
        end
        CHECK: err_q <= (rsum != wsum);
`endif
        DONE: cpu_hold <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
